// File: rtl/id_ex_stage_buf_if.sv
// ID->EX packet channel: valid/ready handshake plus the per-lane decoded
// instruction payload. Lane 0 occupies the LSBs of every packed field.
//   valid/ready          handshake (master drives valid, slave drives ready)
//   lane_vld             per-lane instruction valid
//   ctrl                 per lane {memwrite,memread,memtoreg,alusrc,regwrite,aluop[1:0]}
//   rd/rs1/rs2           register indices (AW bits per lane)
//   rdata1/rdata2/imm    operands and immediate (DW bits per lane)
//   func3/func7          funct3 / funct7 per lane
interface id_ex_stage_buf_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 5
);
  logic                  valid;
  logic                  ready;
  logic [LANES-1:0]      lane_vld;
  logic [LANES*7-1:0]    ctrl;
  logic [LANES*AW-1:0]   rd;
  logic [LANES*AW-1:0]   rs1;
  logic [LANES*AW-1:0]   rs2;
  logic [LANES*DW-1:0]   rdata1;
  logic [LANES*DW-1:0]   rdata2;
  logic [LANES*DW-1:0]   imm;
  logic [LANES*3-1:0]    func3;
  logic [LANES*7-1:0]    func7;

  modport master (
    output valid, lane_vld, ctrl, rd, rs1, rs2, rdata1, rdata2, imm, func3, func7,
    input  ready
  );

  modport slave (
    input  valid, lane_vld, ctrl, rd, rs1, rs2, rdata1, rdata2, imm, func3, func7,
    output ready
  );
endinterface

// File: rtl/id_ex_stage_buf.sv
// ID->EX pipeline boundary: 2-entry elastic buffer (main + skid) with a
// registered valid/ready handshake, synchronous flush, per-lane gating of the
// control bits and a saturating back-pressure cycle counter.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous discard of both entries (branch/exception)
//   in_if      upstream packet channel from decode/regfile read (slave side)
//   out_if     downstream packet channel to ALU/forwarding (master side),
//              payload is the main entry
//   stall_cnt  cycles with out_valid & !out_ready, saturating, reset-only clear
module id_ex_stage_buf #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  id_ex_stage_buf_if.slave   in_if,
  id_ex_stage_buf_if.master  out_if,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Entry split into the part flush must clear (lane_vld + ctrl) and the
  // data/index part that flush leaves untouched.
  localparam int unsigned CW  = LANES * 8;
  localparam int unsigned DPW = LANES * (3 * AW + 3 * DW + 10);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      in_c,   main_c, skid_c;
  logic [DPW-1:0]     in_d,   main_d, skid_d;
  logic [LANES*7-1:0] ctrl_g;
  logic               in_fire, out_fire;

  // Invalid lanes never carry live control into EX.
  always_comb begin
    ctrl_g = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      ctrl_g[i*7 +: 7] = in_if.ctrl[i*7 +: 7] & {7{in_if.lane_vld[i]}};
    end
  end

  assign in_c = {in_if.lane_vld, ctrl_g};
  assign in_d = {in_if.rd, in_if.rs1, in_if.rs2, in_if.rdata1, in_if.rdata2,
                 in_if.imm, in_if.func3, in_if.func7};

  assign {out_if.lane_vld, out_if.ctrl} = main_c;
  assign {out_if.rd, out_if.rs1, out_if.rs2, out_if.rdata1, out_if.rdata2,
          out_if.imm, out_if.func3, out_if.func7} = main_d;

  // Handshake outputs depend on registered state only.
  assign in_if.ready  = (state != SKID);
  assign out_if.valid = (state != EMPTY);

  assign in_fire  = in_if.valid & in_if.ready;
  assign out_fire = out_if.valid & out_if.ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_c <= '0;
      main_d <= '0;
      skid_c <= '0;
      skid_d <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_c <= '0;
      skid_c <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_c <= in_c;
            main_d <= in_d;
            state  <= FULL;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_c <= in_c;
            main_d <= in_d;
          end else if (in_fire) begin
            skid_c <= in_c;
            skid_d <= in_d;
            state  <= SKID;
          end else if (out_fire) begin
            state  <= EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            main_c <= skid_c;
            main_d <= skid_d;
            state  <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_if.valid && !out_if.ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_buf.sv
module tb_id_ex_stage_buf;

  localparam int unsigned PW = 114;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [7:0] stall_cnt;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [PW-1:0] sb[$];

  id_ex_stage_buf_if #(.LANES(2), .DW(8), .AW(5)) up ();
  id_ex_stage_buf_if #(.LANES(2), .DW(8), .AW(5)) dn ();

  id_ex_stage_buf #(.LANES(2), .DW(8), .AW(5), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_if     (up),
    .out_if    (dn),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] in_pkt();
    logic [13:0] gc;
    gc = '0;
    for (int l = 0; l < 2; l++) begin
      if (up.lane_vld[l]) gc[l*7 +: 7] = up.ctrl[l*7 +: 7];
    end
    return {up.lane_vld, gc, up.rd, up.rs1, up.rs2, up.rdata1, up.rdata2,
            up.imm, up.func3, up.func7};
  endfunction

  function automatic logic [PW-1:0] out_pkt();
    return {dn.lane_vld, dn.ctrl, dn.rd, dn.rs1, dn.rs2, dn.rdata1, dn.rdata2,
            dn.imm, dn.func3, dn.func7};
  endfunction

  // Scoreboard: accepted inputs are queued, every downstream transfer must
  // match the oldest queued packet.
  always @(negedge clk) begin
    if (reset && !flush) begin
      if (dn.valid && dn.ready) begin
        if (sb.size() == 0) chk("sb_unexpected_out", 128'(sb.size()), 128'd1);
        else                chk("sb_pkt", 128'(out_pkt()), 128'(sb.pop_front()));
      end
      if (up.valid && up.ready) sb.push_back(in_pkt());
    end else if (reset && flush) begin
      sb.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] lv);
    logic [31:0] r;
    up.valid = v;
    up.lane_vld = lv;
    r = $urandom(); up.ctrl   = r[13:0];
    r = $urandom(); up.rd     = r[9:0];
    r = $urandom(); up.rs1    = r[9:0];
    r = $urandom(); up.rs2    = r[9:0];
    r = $urandom(); up.rdata1 = r[15:0];
    r = $urandom(); up.rdata2 = r[15:0];
    r = $urandom(); up.imm    = r[15:0];
    r = $urandom(); up.func3  = r[5:0];
    r = $urandom(); up.func7  = r[13:0];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0]  rd_exp;
    logic [13:0] ctl;
    reset = 1'b1;
    flush = 1'b0;
    dn.ready = 1'b0;
    drive(1'b0, 2'b00);
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 128'(dn.valid), 128'd0);
    chk("rst_in_ready",  128'(up.ready), 128'd1);
    chk("rst_stall_cnt", 128'(stall_cnt), 128'd0);
    chk("rst_out_ctrl",  128'(dn.ctrl), 128'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    // 1: streaming with no back-pressure
    dn.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b11);
      rd_exp = up.rd;
      step();
      chk("stream_out_valid", 128'(dn.valid), 128'd1);
      chk("stream_in_ready",  128'(up.ready), 128'd1);
      chk("stream_latency_rd", 128'(dn.rd), 128'(rd_exp));
    end
    up.valid = 1'b0;
    step();
    chk("stream_drain", 128'(dn.valid), 128'd0);

    // 2: back-pressure into skid, then drain in order
    dn.ready = 1'b0;
    drive(1'b1, 2'b11); up.rd = 10'd3;
    step();
    chk("bp_a_rd", 128'(dn.rd), 128'd3);
    chk("bp_a_in_ready", 128'(up.ready), 128'd1);
    drive(1'b1, 2'b11); up.rd = 10'd7;
    step();
    chk("bp_b_rd_held", 128'(dn.rd), 128'd3);
    chk("bp_skid_in_ready", 128'(up.ready), 128'd0);
    up.valid = 1'b0;
    step();
    chk("bp_hold_rd", 128'(dn.rd), 128'd3);
    dn.ready = 1'b1;
    step();
    chk("bp_b_rd", 128'(dn.rd), 128'd7);
    chk("bp_b_in_ready", 128'(up.ready), 128'd1);
    step();
    chk("bp_drained", 128'(dn.valid), 128'd0);

    // 3: per-lane control gating
    drive(1'b1, 2'b01);
    up.ctrl = {7'h7F, 7'h55};
    up.rdata1 = {8'hA5, 8'h3C};
    step();
    ctl = dn.ctrl;
    chk("gate_lane1_ctrl", 128'(ctl[13:7]), 128'd0);
    chk("gate_lane0_ctrl", 128'(ctl[6:0]), 128'h55);
    chk("gate_lane_vld", 128'(dn.lane_vld), 128'b01);
    chk("gate_rdata1_hi", 128'(dn.rdata1[15:8]), 128'hA5);
    drive(1'b1, 2'b10);
    up.ctrl = {7'h7F, 7'h7F};
    step();
    ctl = dn.ctrl;
    chk("gate_lane0_off", 128'(ctl[6:0]), 128'd0);
    chk("gate_lane1_on", 128'(ctl[13:7]), 128'h7F);
    up.valid = 1'b0;
    step();

    // 4: flush in SKID, and flush in FULL with a simultaneous in_fire
    dn.ready = 1'b0;
    drive(1'b1, 2'b11);
    step();
    drive(1'b1, 2'b11);
    step();
    chk("fl_skid_in_ready", 128'(up.ready), 128'd0);
    drive(1'b1, 2'b11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    up.valid = 1'b0;
    chk("fl_out_valid", 128'(dn.valid), 128'd0);
    chk("fl_out_ctrl", 128'(dn.ctrl), 128'd0);
    chk("fl_lane_vld", 128'(dn.lane_vld), 128'd0);
    chk("fl_in_ready", 128'(up.ready), 128'd1);
    drive(1'b1, 2'b11);
    step();
    drive(1'b1, 2'b11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    up.valid = 1'b0;
    chk("fl_full_discard", 128'(dn.valid), 128'd0);
    dn.ready = 1'b1;
    drive(1'b1, 2'b11);
    rd_exp = up.rd;
    step();
    chk("fl_after_valid", 128'(dn.valid), 128'd1);
    chk("fl_after_rd", 128'(dn.rd), 128'(rd_exp));
    up.valid = 1'b0;
    step();
    chk("fl_after_drain", 128'(dn.valid), 128'd0);

    // 5: stall counter saturation from a known zero
    step();
    #2 reset = 1'b0;
    sb.delete();
    @(posedge clk);
    #3 reset = 1'b1;
    dn.ready = 1'b0;
    drive(1'b1, 2'b11);
    step();
    up.valid = 1'b0;
    repeat (100) step();
    chk("stall_100", 128'(stall_cnt), 128'd100);
    repeat (200) step();
    chk("stall_sat", 128'(stall_cnt), 128'd255);
    repeat (5) step();
    chk("stall_hold", 128'(stall_cnt), 128'd255);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stall_flush_keep", 128'(stall_cnt), 128'd255);
    chk("stall_flush_valid", 128'(dn.valid), 128'd0);
    step();
    chk("stall_idle_keep", 128'(stall_cnt), 128'd255);

    // 6: async reset mid-SKID
    drive(1'b1, 2'b11);
    step();
    drive(1'b1, 2'b11);
    step();
    up.valid = 1'b0;
    chk("ar_skid_in_ready", 128'(up.ready), 128'd0);
    #2 reset = 1'b0;
    sb.delete();
    #1;
    chk("ar_out_valid", 128'(dn.valid), 128'd0);
    chk("ar_in_ready", 128'(up.ready), 128'd1);
    chk("ar_stall_cnt", 128'(stall_cnt), 128'd0);
    chk("ar_out_rd", 128'(dn.rd), 128'd0);
    chk("ar_out_ctrl", 128'(dn.ctrl), 128'd0);
    chk("ar_out_rdata1", 128'(dn.rdata1), 128'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    dn.ready = 1'b1;
    drive(1'b1, 2'b11);
    rd_exp = up.rd;
    step();
    chk("ar_new_valid", 128'(dn.valid), 128'd1);
    chk("ar_new_rd", 128'(dn.rd), 128'(rd_exp));
    up.valid = 1'b0;
    step();
    chk("ar_new_drain", 128'(dn.valid), 128'd0);
    chk("sb_empty_at_end", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
